// File: rtl/post_gain_stage_if.sv
// post_gain_stage_if: sample, gain and clip signals between the effects
// pipeline and the output gain stage.
interface post_gain_stage_if #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16
) ();
  logic                     i_valid;
  logic signed [DATA_W-1:0] i_sample;
  logic        [GAIN_W-1:0] i_gain;
  logic                     i_clip_clr;
  logic                     o_valid;
  logic signed [DATA_W-1:0] o_sample;
  logic        [GAIN_W-1:0] o_gain_cur;
  logic                     o_clip;
  logic                     o_clip_sticky;

  // Gain stage view
  modport slave (
    input  i_valid, i_sample, i_gain, i_clip_clr,
    output o_valid, o_sample, o_gain_cur, o_clip, o_clip_sticky
  );

  // Effects pipeline / sink view
  modport master (
    output i_valid, i_sample, i_gain, i_clip_clr,
    input  o_valid, o_sample, o_gain_cur, o_clip, o_clip_sticky
  );
endinterface

// File: rtl/post_gain_stage.sv
// post_gain_stage: registered saturating fixed-point gain with optional
// gain slewing and clip reporting.
// Optional feature macro: POST_GAIN_RAMP_EN -- when defined the applied gain
// moves toward i_gain by at most RAMP_STEP per accepted sample; otherwise it
// loads i_gain directly on every accepted sample.
module post_gain_stage #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 4,
  parameter int RAMP_STEP = 1
) (
  input logic              clk,
  input logic              rst,
  post_gain_stage_if.slave bus
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1) << GAIN_FRAC;
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef POST_GAIN_RAMP_EN
  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);
`else
  // An unbounded step makes gain_cur land on i_gain in a single move.
  localparam logic [GAIN_W-1:0] STEP = {GAIN_W{1'b1}} | GAIN_W'(RAMP_STEP);
`endif

  logic        [GAIN_W-1:0] gain_cur;
  logic        [GAIN_W-1:0] gain_next;
  logic        [GAIN_W-1:0] gain_diff;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_sample;
  logic signed [PROD_W-1:0] mul_a;
  logic signed [PROD_W-1:0] mul_b;
  logic                     s2_valid;
  logic signed [PROD_W-1:0] s2_prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [DATA_W-1:0] sat;
  logic                     clip;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_sample;
  logic                     out_clip;
  logic                     sticky;

  // Move the applied gain toward the target by at most STEP.
  always_comb begin
    gain_next = gain_cur;
    gain_diff = '0;
    if (gain_cur < bus.i_gain) begin
      gain_diff = bus.i_gain - gain_cur;
      gain_next = gain_cur + ((gain_diff > STEP) ? STEP : gain_diff);
    end else if (gain_cur > bus.i_gain) begin
      gain_diff = gain_cur - bus.i_gain;
      gain_next = gain_cur - ((gain_diff > STEP) ? STEP : gain_diff);
    end
  end

  // Stage 1: capture the sample and update the applied gain on each strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_sample <= '0;
      gain_cur  <= GAIN_UNITY;
    end else begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sample <= bus.i_sample;
        gain_cur  <= gain_next;
      end
    end
  end

  // Full-width operands: signed sample times zero-extended unsigned gain.
  assign mul_a = PROD_W'(s1_sample);
  assign mul_b = PROD_W'($signed({1'b0, gain_cur}));

  // Stage 2: register the untruncated product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= mul_a * mul_b;
      end
    end
  end

  // Drop fraction bits (arithmetic shift floors) and clamp to sample range.
  always_comb begin
    shifted = s2_prod >>> GAIN_FRAC;
    sat     = shifted[DATA_W-1:0];
    clip    = 1'b0;
    if (shifted > SAT_MAX) begin
      sat  = SAT_MAX[DATA_W-1:0];
      clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat  = SAT_MIN[DATA_W-1:0];
      clip = 1'b1;
    end
  end

  // Output register and sticky clip; a set (loading or showing a clip) beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_clip   <= 1'b0;
      sticky     <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sample <= sat;
        out_clip   <= clip;
      end
      sticky <= (s2_valid & clip) | (out_valid & out_clip) |
                (sticky & ~bus.i_clip_clr);
    end
  end

  assign bus.o_valid       = out_valid;
  assign bus.o_sample      = out_sample;
  assign bus.o_clip        = out_clip;
  assign bus.o_clip_sticky = sticky;
  assign bus.o_gain_cur    = gain_cur;

endmodule

// File: doc/post_gain_stage.md
# post_gain_stage

Output gain stage between the effects pipeline and the sign-to-unsigned/I2S output path. It replaces the raw unsaturated `sample * gain` product with a registered, saturating fixed-point multiply. The applied gain slews toward the requested value to avoid zipper noise, and the block reports clipping. It runs on the audio clock domain, accepts one sample per `i_valid` strobe and emits one `o_valid`-qualified signed sample.

## Interface
- `DATA_W`, 16: signed sample width, input and output.
- `GAIN_W`, 16: unsigned gain width.
- `GAIN_FRAC`, 4: fractional bits of the gain. Unity gain = `1 << GAIN_FRAC`.
- `RAMP_STEP`, 1: maximum gain change per accepted sample (ramp build only).
- `clk`  in  1: audio clock, same as the effects pipeline clock.
- `rst`  in  1: reset, asynchronous assert, active-low (0 = reset).
- `i_valid`  in  1: sample strobe from the effects pipeline. May be high on consecutive cycles.
- `i_sample`  in  DATA_W: signed two's-complement input sample.
- `i_gain`  in  GAIN_W: target gain, unsigned, Q(GAIN_W-GAIN_FRAC).GAIN_FRAC.
- `i_clip_clr`  in  1: clears the sticky clip flag.
- `o_valid`  out  1: output sample strobe.
- `o_sample`  out  DATA_W: signed, saturated output sample.
- `o_gain_cur`  out  GAIN_W: gain currently applied.
- `o_clip`  out  1: high together with `o_valid` when that sample saturated.
- `o_clip_sticky`  out  1: latched clip indicator.

## Operation
- Two-stage pipeline. Both stages advance only on their valid bit. Throughput is 1 sample/cycle.
- **Stage 1**, on the `i_valid` edge:
  - Register `i_sample`.
  - Update `gain_cur` toward `i_gain`:
    - If `gain_cur < i_gain`: `gain_cur += min(RAMP_STEP, i_gain - gain_cur)`.
    - If `gain_cur > i_gain`: `gain_cur -= min(RAMP_STEP, gain_cur - i_gain)`.
    - If equal: hold.
  - The captured sample is multiplied by the *updated* `gain_cur`.
  - `i_gain` is sampled only on `i_valid`. Changes between strobes have no effect.
- **Stage 2:**
  - Product = `i_sample` (signed) × `{1'b0, gain_cur}`, full width DATA_W+GAIN_W+1, no intermediate truncation.
  - Arithmetic right shift by GAIN_FRAC, which is floor rounding.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - `o_clip` = 1 when the saturation clamp was active.
- **Sticky flag:** set on any `o_clip`, cleared by `i_clip_clr`. On a same-cycle set and clear, set wins.
- **Gain 0:** output 0, no clip.
- **Gain at max:** no overflow inside the product.
- **Reset** (`rst` = 0, at any time including mid-pipeline):
  - Pipeline valids cleared; in-flight samples are dropped and never emitted.
  - `gain_cur` = `1 << GAIN_FRAC`.
  - After reset release, the first `i_valid` starts the ramp from unity.

## Timing
- Latency: `i_valid` sampled at edge N gives `o_valid` high in the cycle after edge N+2 (2 clocks).
- `o_valid` is a single-cycle pulse per input strobe. Back-to-back inputs give back-to-back outputs.
- `o_sample` and `o_clip` are registered. They hold their value between strobes.
- `o_gain_cur` is registered and changes on the edge that accepts `i_valid`.
- Reset values:
  - `o_valid` = 0, `o_sample` = 0, `o_clip` = 0, `o_clip_sticky` = 0.
  - `o_gain_cur` = `1 << GAIN_FRAC`.
- All outputs reach reset values asynchronously on `rst` falling and stay there while `rst` = 0.

## Configuration
- `POST_GAIN_RAMP_EN`:
  - Defined: gain slews by at most RAMP_STEP per accepted sample, as above.
  - Undefined: `gain_cur` loads `i_gain` directly on each `i_valid`. RAMP_STEP is unused. Latency and saturation behaviour are unchanged.

## Test plan
Defaults for all cases: GAIN_FRAC = 4, DATA_W = 16.
- **Unity gain:** reset, `i_gain` = 16, `i_sample` = 1000 with one `i_valid` → `o_valid` 2 clocks later, `o_sample` = 1000, `o_clip` = 0.
- **Saturation:**
  - `i_gain` = 32 at steady state, `i_sample` = 20000 → 32767, `o_clip` = 1, `o_clip_sticky` = 1.
  - `i_sample` = -20000 → -32768.
  - `i_clip_clr` pulse with no clip → sticky = 0.
  - `i_clip_clr` coincident with a clipping output → sticky stays 1.
- **Floor rounding:** `i_gain` = 8 (0.5) at steady state.
  - `i_sample` = -1 → -1.
  - `i_sample` = 3 → 1.
  - `i_sample` = -3 → -2.
- **Ramp (macro defined, RAMP_STEP = 1):**
  - From reset, `i_gain` = 20, four back-to-back strobes with `i_sample` = 16 → `o_gain_cur` 17, 18, 19, 20 and outputs 17, 18, 19, 20.
  - `i_gain` then = 18 → two strobes give 19, 18.
- **No ramp (macro undefined):** same stimulus → `o_gain_cur` = 20 after the first strobe, all outputs 20.
- **Reset mid-operation:** assert `rst` = 0 one clock after an `i_valid` → no `o_valid` ever appears for that sample, and all outputs are at reset values immediately.
